// File: rtl/avalon_irq_aggregator_if.sv
// Avalon-MM slave register bus used by avalon_irq_aggregator.
// Fixed format: 16-bit data, 3-bit word address, active-low write strobe,
// and registered read data.
interface avalon_irq_aggregator_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/avalon_irq_aggregator.sv
// avalon_irq_aggregator
// Collects up to 16 peripheral irq lines. Each line is latched either as a
// level or as a rising edge. The latched bits are masked, and the block drives
// one combined irq plus the ID of the highest-priority active source, where
// bit 0 has the highest priority.
//
// Register map (word address):
//   0 STATUS, 1 MASK, 2 PENDING (W1C), 3 EDGE_SEL, 4 ACTIVE, 5 FORCE.
//   Addresses 6 and 7 read as 0.
//
// Optional build macro IRQ_AGG_SYNC_EN adds a 2-flop synchronizer on irq_in,
// which allows asynchronous sources. It adds 2 cycles to every latency.
module avalon_irq_aggregator #(
   parameter int NUM_IRQ = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   avalon_irq_aggregator_if.slave bus,
   input  logic [NUM_IRQ-1:0]     irq_in,
   output logic                   irq,
   output logic [3:0]             irq_id
);

   // Bits at and above NUM_IRQ never hold state and always read 0.
   localparam logic [15:0] VALID_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

   logic [NUM_IRQ-1:0] irq_src;
   logic [15:0]        irq_ext;
   logic [15:0]        irq_d;
   logic [15:0]        mask;
   logic [15:0]        edge_sel;
   logic [15:0]        pending;
   logic [15:0]        pending_next;
   logic [15:0]        active;
   logic [15:0]        rise;
   logic [15:0]        force_bits;
   logic [15:0]        w1c_bits;
   logic [15:0]        read_mux;
   logic [3:0]         id_next;
   logic               wr_mask;
   logic               wr_pending;
   logic               wr_edge_sel;
   logic               wr_force;

`ifdef IRQ_AGG_SYNC_EN
   logic [NUM_IRQ-1:0] sync_meta;
   logic [NUM_IRQ-1:0] sync_out;

   // Two-flop synchronizer so that asynchronous peripherals can drive irq_in
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= '0;
         sync_out  <= '0;
      end else begin
         sync_meta <= irq_in;
         sync_out  <= sync_meta;
      end
   end

   assign irq_src = sync_out;
`else
   assign irq_src = irq_in;
`endif

   // Widen the source lines to the 16-bit register format, with unused bits at 0
   always_comb begin
      irq_ext = '0;
      irq_ext[NUM_IRQ-1:0] = irq_src;
   end

   assign wr_mask     = bus.chipselect && !bus.write_n && (bus.address == 3'd1);
   assign wr_pending  = bus.chipselect && !bus.write_n && (bus.address == 3'd2);
   assign wr_edge_sel = bus.chipselect && !bus.write_n && (bus.address == 3'd3);
   assign wr_force    = bus.chipselect && !bus.write_n && (bus.address == 3'd5);

   assign rise       = irq_ext & ~irq_d;
   assign force_bits = wr_force   ? bus.writedata : 16'h0000;
   assign w1c_bits   = wr_pending ? bus.writedata : 16'h0000;
   assign active     = pending & mask;

   // Level bits follow the line. Edge bits are sticky, and a set wins over a
   // W1C in the same cycle.
   always_comb begin
      pending_next = ((~edge_sel & irq_ext) |
                      (edge_sel & ((pending & ~w1c_bits) | rise | force_bits)))
                     & VALID_MASK;
   end

   // Lowest set active bit wins; 0 when nothing is active
   always_comb begin
      id_next = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (active[i]) id_next = 4'(i);
      end
   end

   // Register read mux, evaluated every cycle regardless of chipselect
   always_comb begin
      read_mux = 16'h0000;
      case (bus.address)
         3'd0:    read_mux = active;
         3'd1:    read_mux = mask;
         3'd2:    read_mux = pending;
         3'd3:    read_mux = edge_sel;
         3'd4:    read_mux = {|active, 11'b0, id_next};
         default: read_mux = 16'h0000;
      endcase
   end

   // Control registers, pending latch, edge-detect history, and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask         <= '0;
         edge_sel     <= '0;
         pending      <= '0;
         irq_d        <= '0;
         bus.readdata <= '0;
         irq          <= 1'b0;
         irq_id       <= 4'd0;
      end else begin
         if (wr_mask)     mask     <= bus.writedata & VALID_MASK;
         if (wr_edge_sel) edge_sel <= bus.writedata & VALID_MASK;
         pending      <= pending_next;
         irq_d        <= irq_ext;
         bus.readdata <= read_mux;
         irq          <= |active;
         irq_id       <= id_next;
      end
   end

endmodule

// File: tb/tb_avalon_irq_aggregator.sv
// Directed testbench for avalon_irq_aggregator (NUM_IRQ = 8).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_avalon_irq_aggregator;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] irq_in;
   logic       irq;
   logic [3:0] irq_id;
   int         checks = 0;
   int         errors = 0;

   avalon_irq_aggregator_if bus ();

   avalon_irq_aggregator #(.NUM_IRQ(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .irq_in  (irq_in),
      .irq     (irq),
      .irq_id  (irq_id)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      @(negedge clk);
      d = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   task automatic test_reset;
      logic [15:0] d;
      reset_n = 1'b0;
      irq_in  = 8'h00;
      bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 16'h0;
      #3;
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b expected 0", irq); end
      checks++; if (irq_id !== 4'd0) begin errors++; $display("[TB] FAIL reset_irq_id got %0d expected 0", irq_id); end
      checks++; if (bus.readdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_readdata got %h expected 0000", bus.readdata); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      bus_read(3'd1, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mask got %h expected 0000", d); end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pending got %h expected 0000", d); end
   endtask

   task automatic test_level;
      logic [15:0] d;
      bus_write(3'd1, 16'h0001);
      irq_in[0] = 1'b1;
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL level_irq_early got %b expected 0", irq); end
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL level_irq got %b expected 1", irq); end
      checks++; if (irq_id !== 4'd0) begin errors++; $display("[TB] FAIL level_irq_id got %0d expected 0", irq_id); end
      bus_read(3'd0, d);
      checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL level_status got %h expected 0001", d); end
      irq_in[0] = 1'b0;
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL level_drop_early got %b expected 1", irq); end
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL level_drop got %b expected 0", irq); end
   endtask

   task automatic test_edge;
      logic [15:0] d;
      bus_write(3'd3, 16'h0004);
      bus_write(3'd1, 16'h0004);
      irq_in[2] = 1'b1;
      @(negedge clk);
      irq_in[2] = 1'b0;
      repeat (2) @(negedge clk);
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0004) begin errors++; $display("[TB] FAIL edge_pending_held got %h expected 0004", d); end
      checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL edge_irq got %b expected 1", irq); end
      checks++; if (irq_id !== 4'd2) begin errors++; $display("[TB] FAIL edge_irq_id got %0d expected 2", irq_id); end
      bus_write(3'd2, 16'h0004);
      checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL edge_w1c_early got %b expected 1", irq); end
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL edge_w1c_irq got %b expected 0", irq); end
      // a line held high latches only one event
      irq_in[2] = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0004) begin errors++; $display("[TB] FAIL edge_hold_set got %h expected 0004", d); end
      bus_write(3'd2, 16'h0004);
      repeat (2) @(negedge clk);
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL edge_hold_once got %h expected 0000", d); end
      irq_in[2] = 1'b0;
   endtask

   task automatic test_priority;
      logic [15:0] d;
      bus_write(3'd3, 16'h0000);
      bus_write(3'd1, 16'h00FF);
      irq_in[5] = 1'b1;
      irq_in[3] = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (irq_id !== 4'd3) begin errors++; $display("[TB] FAIL prio_id_3 got %0d expected 3", irq_id); end
      bus_read(3'd4, d);
      checks++; if (d !== 16'h8003) begin errors++; $display("[TB] FAIL prio_active_3 got %h expected 8003", d); end
      irq_in[3] = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (irq_id !== 4'd5) begin errors++; $display("[TB] FAIL prio_id_5 got %0d expected 5", irq_id); end
      bus_read(3'd4, d);
      checks++; if (d !== 16'h8005) begin errors++; $display("[TB] FAIL prio_active_5 got %h expected 8005", d); end
      irq_in[5] = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL prio_idle got %b expected 0", irq); end
   endtask

   task automatic test_collision;
      logic [15:0] d;
      bus_write(3'd3, 16'h0002);
      @(negedge clk);
      irq_in[1]      = 1'b1;
      bus.address    = 3'd2;
      bus.writedata  = 16'h0002;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0002) begin errors++; $display("[TB] FAIL collide_set_wins got %h expected 0002", d); end
      bus_write(3'd2, 16'h0002);
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL collide_later_clear got %h expected 0000", d); end
      irq_in[1] = 1'b0;
   endtask

   task automatic test_force;
      logic [15:0] d;
      bus_write(3'd1, 16'h0000);
      bus_write(3'd3, 16'h0010);
      bus_write(3'd5, 16'h0010);
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0010) begin errors++; $display("[TB] FAIL force_pending got %h expected 0010", d); end
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL force_masked_irq got %b expected 0", irq); end
      bus_write(3'd5, 16'h0001);
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0010) begin errors++; $display("[TB] FAIL force_level_ignored got %h expected 0010", d); end
      bus_read(3'd5, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL force_read_zero got %h expected 0000", d); end
      bus_write(3'd1, 16'h0010);
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL force_unmask_early got %b expected 0", irq); end
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL force_unmask_irq got %b expected 1", irq); end
      checks++; if (irq_id !== 4'd4) begin errors++; $display("[TB] FAIL force_irq_id got %0d expected 4", irq_id); end
      bus_read(3'd0, d);
      checks++; if (d !== 16'h0010) begin errors++; $display("[TB] FAIL force_status got %h expected 0010", d); end
   endtask

   task automatic test_reset_mid;
      logic [15:0] d;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL midreset_irq got %b expected 0", irq); end
      checks++; if (irq_id !== 4'd0) begin errors++; $display("[TB] FAIL midreset_irq_id got %0d expected 0", irq_id); end
      checks++; if (bus.readdata !== 16'h0) begin errors++; $display("[TB] FAIL midreset_readdata got %h expected 0000", bus.readdata); end
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(3'd1, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_mask got %h expected 0000", d); end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_pending got %h expected 0000", d); end
   endtask

   task automatic test_unused_bits;
      logic [15:0] d;
      bus_write(3'd3, 16'hFFFF);
      bus_read(3'd3, d);
      checks++; if (d !== 16'h00FF) begin errors++; $display("[TB] FAIL unused_edge_sel got %h expected 00FF", d); end
      bus_write(3'd1, 16'hFFFF);
      bus_read(3'd1, d);
      checks++; if (d !== 16'h00FF) begin errors++; $display("[TB] FAIL unused_mask got %h expected 00FF", d); end
      bus_write(3'd5, 16'hFFFF);
      bus_read(3'd2, d);
      checks++; if (d !== 16'h00FF) begin errors++; $display("[TB] FAIL unused_pending got %h expected 00FF", d); end
      checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL unused_irq got %b expected 1", irq); end
      checks++; if (irq_id !== 4'd0) begin errors++; $display("[TB] FAIL unused_irq_id got %0d expected 0", irq_id); end
      bus_write(3'd6, 16'hFFFF);
      bus_read(3'd6, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL addr6_read got %h expected 0000", d); end
      bus_read(3'd7, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL addr7_read got %h expected 0000", d); end
      bus_write(3'd2, 16'hFFFF);
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL unused_w1c_all got %h expected 0000", d); end
   endtask

   initial begin
      test_reset();
      test_level();
      test_edge();
      test_priority();
      test_collision();
      test_force();
      test_reset_mid();
      test_unused_bits();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/avalon_irq_aggregator.md
Name: avalon_irq_aggregator

Overview:
- Avalon-MM interrupt aggregator that sits directly downstream of the interval timers and other peripheral slaves.
- Collects up to 16 peripheral irq lines and latches them per source as level or rising-edge.
- Masks them and drives one combined irq plus the highest-priority source ID to the CPU.
- Register interface is the same 16-bit, 3-bit-address, registered-read slave style the peripherals use.

Parameters:
- NUM_IRQ, 8, number of irq inputs used (1..16); register bits at and above NUM_IRQ read 0 and ignore writes.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  3  word address of the register
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  16  write data
- irq_in  input  NUM_IRQ  peripheral interrupt lines, active high, clk domain
- readdata  output  16  registered read data
- irq  output  1  combined interrupt to CPU, registered
- irq_id  output  4  index of the highest-priority active source, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. All flops clear on reset: mask, edge_sel, pending, the irq_in delay register, readdata, irq and irq_id all reset to 0.
- Write strobe per address: wr_a = chipselect && ~write_n && (address==a).
- Register map:
  - 0 STATUS R: pending & mask. Writes are ignored.
  - 1 MASK RW: 1 enables the source.
  - 2 PENDING R/W1C: reads the raw pending bits. Writing 1 clears an edge-mode bit.
  - 3 EDGE_SEL RW: 1 = rising-edge latch, 0 = level.
  - 4 ACTIVE R: bit15 = any active, bits3:0 = irq_id, all other bits 0.
  - 5 FORCE W: writing 1 sets the pending bit (edge-mode sources only). Reads return 0.
  - 6 and 7: read 0; writes are ignored.
- Read path: readdata <= read mux on every clock, independent of chipselect. This gives one cycle of read latency.
- Level source (edge_sel[i]=0): pending[i] <= irq_in[i] every cycle. W1C and FORCE have no effect on it.
- Edge source (edge_sel[i]=1):
  - Rising-edge detect: rise[i] = irq_in[i] & ~irq_d[i], with irq_d <= irq_in every cycle.
  - Set and clear priority: (rise | force_bit) sets the pending bit, and set wins over a simultaneous W1C.
  - If irq_in is held high, only one event is latched.
  - irq_d resets to 0, so a line that is high when reset is released counts as one edge.
- Switching EDGE_SEL from 1 to 0 makes the bit follow the level from the next cycle. Switching from 0 to 1 keeps the current pending value.
- Outputs:
  - active = pending & mask.
  - irq <= |active.
  - irq_id <= index of the lowest set bit of active (bit 0 is highest priority), or 0 if none.
- Latency: irq_in sampled high at edge k gives pending at k, then irq and irq_id at k+1. irq first becomes visible after the second rising edge. An MASK write at edge k affects irq at k+1.
- Deassertion: a W1C of the last active edge bit at edge k drops irq at k+1.
- Asserting reset_n low mid-operation clears everything immediately. No event is retained.

Optional Feature:
- Macro: IRQ_AGG_SYNC_EN.
- When defined: irq_in passes through a 2-flop synchronizer (reset to 0) before the edge detect and level paths. This adds 2 cycles to every latency above and permits asynchronous sources.
- When undefined: irq_in is used directly. Sources must be synchronous to clk.

Test Plan:
- Level path: NUM_IRQ=8, MASK=0x0001, irq_in[0] rises at edge 10 → irq=1 and irq_id=0 after edge 11, STATUS read = 0x0001. Drop irq_in[0] → irq=0 two edges later.
- Edge path: EDGE_SEL=0x0004, MASK=0x0004, 1-cycle pulse on irq_in[2] → PENDING=0x0004 is held after the pulse ends. Write 0x0004 to addr 2 → irq=0 one edge later.
- Priority: MASK=0x00FF, irq_in[5] and irq_in[3] high together → irq_id=3, ACTIVE read = 0x8003. Clear 3 (level drop) → irq_id=5, ACTIVE=0x8005.
- Set and clear collision: edge mode on bit 1, a rising edge on the same cycle as a W1C of 0x0002 → PENDING bit1 remains 1.
- FORCE and masking: MASK=0, write 0x0010 to addr 5 with EDGE_SEL bit4=1 → PENDING=0x0010 and irq=0. Write MASK=0x0010 → irq=1 one edge later.
- Reset: assert reset_n low mid-pending → irq, irq_id, readdata, MASK and PENDING are 0 immediately. Bits ≥ NUM_IRQ written to 1 read back as 0.
